// File: rtl/color_analysis_hls_deadlock_reporter.sv
// color_analysis_hls_deadlock_reporter: qualifies the deadlock block flag and streams a 3-word stall report
module color_analysis_hls_deadlock_reporter #(
  parameter int NUM_PROC = 12,
  parameter int NUM_AXIS = 5,
  parameter int THRESHOLD = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                block_in,
  input  logic [NUM_PROC-1:0] inst_idle_sigs,
  input  logic [NUM_PROC-1:0] inst_block_sigs,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic                clear,
  output logic [31:0]         rpt_tdata,
  output logic                rpt_tvalid,
  output logic                rpt_tlast,
  input  logic                rpt_tready,
  output logic                deadlock,
  output logic [15:0]         event_count
);
  localparam logic [15:0] TH = 16'(THRESHOLD);
  typedef enum logic [2:0] {IDLE, ARM, SEND0, SEND1, SEND2, HOLD} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic declare;
  logic [NUM_PROC-1:0] idle_s, blk_s;
  logic [NUM_AXIS-1:0] axis_s;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    declare = 1'b0;
    case (state)
      IDLE: if (block_in) begin
        cnt_n = 16'd1;
        declare = TH == 16'd1;
        state_n = ARM;
      end
      ARM: begin
        cnt_n = block_in ? cnt + 16'd1 : 16'd0;
        declare = block_in && (cnt + 16'd1 == TH);
        state_n = block_in ? ARM : IDLE;
      end
      SEND0: state_n = rpt_tready ? SEND1 : SEND0;
      SEND1: state_n = rpt_tready ? SEND2 : SEND1;
      SEND2: state_n = rpt_tready ? HOLD : SEND2;
      HOLD: if (clear) begin
        state_n = IDLE;
        cnt_n = 16'd0;
      end
      default: state_n = IDLE;
    endcase
    if (declare) state_n = SEND0;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      idle_s <= '0;
      blk_s <= '0;
      axis_s <= '0;
      event_count <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (declare) begin
        idle_s <= inst_idle_sigs;
        blk_s <= inst_block_sigs;
        axis_s <= axis_block_sigs;
        event_count <= event_count == 16'hFFFF ? event_count : event_count + 16'd1;
      end
    end
  end
  assign rpt_tvalid = state == SEND0 || state == SEND1 || state == SEND2;
  assign rpt_tlast = state == SEND2;
  assign deadlock = rpt_tvalid || state == HOLD;
  assign rpt_tdata = state == SEND0 ? {16'hDEAD, event_count} :
                     state == SEND1 ? {16'(blk_s), 16'(idle_s)} :
                     state == SEND2 ? 32'(axis_s) : 32'd0;
endmodule

// File: tb/tb_color_analysis_hls_deadlock_reporter.sv
// tb_color_analysis_hls_deadlock_reporter: directed self-checking bench for the deadlock reporter
module tb_color_analysis_hls_deadlock_reporter;
  logic clock = 1'b0, reset = 1'b0, block_in = 1'b0, block_in_1 = 1'b0;
  logic clear = 1'b0, clear_1 = 1'b0, rpt_tready = 1'b0;
  logic [11:0] inst_idle_sigs = '0, inst_block_sigs = '0;
  logic [4:0] axis_block_sigs = '0;
  logic [31:0] rpt_tdata, rpt_tdata_1;
  logic rpt_tvalid, rpt_tlast, deadlock, rpt_tvalid_1, rpt_tlast_1, deadlock_1;
  logic [15:0] event_count, event_count_1;
  int total = 0, bad = 0, cycles;
  logic seen;
  always #5 clock = ~clock;
  color_analysis_hls_deadlock_reporter u0 (
    .clock(clock), .reset(reset), .block_in(block_in), .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs), .axis_block_sigs(axis_block_sigs), .clear(clear),
    .rpt_tdata(rpt_tdata), .rpt_tvalid(rpt_tvalid), .rpt_tlast(rpt_tlast), .rpt_tready(rpt_tready),
    .deadlock(deadlock), .event_count(event_count));
  color_analysis_hls_deadlock_reporter #(.THRESHOLD(1)) u1 (
    .clock(clock), .reset(reset), .block_in(block_in_1), .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs), .axis_block_sigs(axis_block_sigs), .clear(clear_1),
    .rpt_tdata(rpt_tdata_1), .rpt_tvalid(rpt_tvalid_1), .rpt_tlast(rpt_tlast_1), .rpt_tready(rpt_tready),
    .deadlock(deadlock_1), .event_count(event_count_1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clock);
  endtask
  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask
  task automatic recv(input string tag, input int stall, input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    logic [31:0] exp [3];
    int n = 0, k = 0, bad_words = 0, c = 0;
    exp = '{w0, w1, w2};
    while (n < 3 && c < 60) begin
      rpt_tready = k == stall;
      if (rpt_tvalid) begin
        if (rpt_tdata !== exp[n] || rpt_tlast !== (n == 2)) bad_words++;
        if (rpt_tready) begin
          n++;
          k = 0;
        end else k++;
      end
      tick();
      c++;
    end
    chk({tag, "_xfers"}, n, 3);
    chk({tag, "_words"}, bad_words, 0);
    chk({tag, "_cycles"}, c, 3 * (stall + 1));
    chk({tag, "_valid_after"}, rpt_tvalid, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    #2;
    chk("rst_valid", rpt_tvalid, 0);
    chk("rst_deadlock", deadlock, 0);
    chk("rst_count", event_count, 0);
    chk("rst_data", rpt_tdata, 0);
    chk("rst_last", rpt_tlast, 0);
    tick();
    reset = 1'b1;
    seen = 1'b0;
    block_in = 1'b1;
    repeat (15) begin tick(); seen |= deadlock | rpt_tvalid; end
    block_in = 1'b0;
    tick();
    block_in = 1'b1;
    repeat (15) begin tick(); seen |= deadlock | rpt_tvalid; end
    block_in = 1'b0;
    tick();
    chk("short_runs_seen", seen, 0);
    chk("short_runs_count", event_count, 0);
    inst_idle_sigs = 12'h0F0;
    inst_block_sigs = 12'h00F;
    axis_block_sigs = 5'b10100;
    block_in = 1'b1;
    repeat (15) tick();
    chk("pre_thresh_deadlock", deadlock, 0);
    tick();
    chk("lat_deadlock", deadlock, 1);
    chk("lat_valid", rpt_tvalid, 1);
    chk("lat_count", event_count, 1);
    recv("b2b", 0, 32'hDEAD0001, 32'h000F00F0, 32'h00000014);
    chk("hold_deadlock", deadlock, 1);
    block_in = 1'b0;
    pulse_clear();
    chk("cleared", deadlock, 0);
    block_in = 1'b1;
    repeat (16) tick();
    block_in = 1'b0;
    recv("stall", 5, 32'hDEAD0002, 32'h000F00F0, 32'h00000014);
    pulse_clear();
    block_in = 1'b1;
    repeat (16) tick();
    chk("t4_valid", rpt_tvalid, 1);
    rpt_tready = 1'b1;
    tick();
    rpt_tready = 1'b0;
    pulse_clear();
    chk("clear_in_send_deadlock", deadlock, 1);
    chk("clear_in_send_data", rpt_tdata, 32'h000F00F0);
    rpt_tready = 1'b1;
    repeat (2) tick();
    rpt_tready = 1'b0;
    chk("t4_hold_valid", rpt_tvalid, 0);
    chk("t4_hold_deadlock", deadlock, 1);
    pulse_clear();
    chk("t4_cleared", deadlock, 0);
    seen = 1'b0;
    repeat (15) begin tick(); seen |= deadlock; end
    chk("requal_early", seen, 0);
    tick();
    chk("requal_deadlock", deadlock, 1);
    chk("requal_word0", rpt_tdata, 32'hDEAD0004);
    rpt_tready = 1'b1;
    repeat (3) tick();
    block_in = 1'b0;
    pulse_clear();
    inst_idle_sigs = 12'hA5C;
    inst_block_sigs = 12'h3C1;
    axis_block_sigs = 5'b00011;
    block_in = 1'b1;
    repeat (16) tick();
    block_in = 1'b0;
    rpt_tready = 1'b1;
    tick();
    rpt_tready = 1'b0;
    chk("pre_reset_word1", rpt_tdata, 32'h03C10A5C);
    reset = 1'b0;
    #1;
    chk("async_valid", rpt_tvalid, 0);
    chk("async_deadlock", deadlock, 0);
    chk("async_count", event_count, 0);
    tick();
    reset = 1'b1;
    block_in = 1'b1;
    repeat (16) tick();
    block_in = 1'b0;
    recv("post_reset", 2, 32'hDEAD0001, 32'h03C10A5C, 32'h00000003);
    pulse_clear();
    rpt_tready = 1'b0;
    block_in_1 = 1'b1;
    tick();
    block_in_1 = 1'b0;
    chk("th1_deadlock", deadlock_1, 1);
    chk("th1_word0", rpt_tdata_1, 32'hDEAD0001);
    chk("th1_last0", rpt_tlast_1, 0);
    rpt_tready = 1'b1;
    tick();
    chk("th1_word1", rpt_tdata_1, 32'h03C10A5C);
    tick();
    chk("th1_word2", rpt_tdata_1, 32'h00000003);
    chk("th1_last2", rpt_tlast_1, 1);
    tick();
    chk("th1_valid_after", rpt_tvalid_1, 0);
    clear_1 = 1'b1;
    tick();
    clear_1 = 1'b0;
    chk("th1_cleared", deadlock_1, 0);
    force u1.event_count = 16'hFFFF;
    block_in_1 = 1'b1;
    tick();
    release u1.event_count;
    block_in_1 = 1'b0;
    chk("sat_word0", rpt_tdata_1, 32'hDEADFFFF);
    repeat (3) tick();
    clear_1 = 1'b1;
    tick();
    clear_1 = 1'b0;
    block_in_1 = 1'b1;
    tick();
    block_in_1 = 1'b0;
    chk("sat_hold_word0", rpt_tdata_1, 32'hDEADFFFF);
    chk("sat_hold_count", event_count_1, 16'hFFFF);
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
